// File: rtl/anc_scheduler.sv
// Frame sequencer for the ANC datapath: lowpass -> sample buffer -> (NLMS) -> FIR.
// Tracks per-stage timeouts, dropped samples and frame latency.
module anc_scheduler #(
  parameter int TIMEOUT_CYCLES = 2047,
  parameter int CNT_W          = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             sample_pulse_in,
  input  logic             adapt_en_in,
  input  logic             clear_flags_in,
  output logic             lp_start_out,
  input  logic             lp_amb_done_in,
  input  logic             lp_fb_done_in,
  output logic             samp_start_out,
  input  logic             samp_done_in,
  output logic             lms_start_out,
  input  logic             lms_done_in,
  output logic             fir_start_out,
  input  logic             fir_done_in,
  output logic             frame_done_out,
  output logic             busy_out,
  output logic             overrun_out,
  output logic             timeout_out,
  output logic [CNT_W-1:0] drop_count_out,
  output logic [CNT_W-1:0] last_latency_out,
  output logic [2:0]       state_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LP    = 3'd1;
  localparam logic [2:0] S_SAMP  = 3'd2;
  localparam logic [2:0] S_ADAPT = 3'd3;
  localparam logic [2:0] S_FIR   = 3'd4;

  localparam int               WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [2:0]        state_q, state_d;
  logic              lp_start_q, lp_start_d;
  logic              samp_start_q, samp_start_d;
  logic              lms_start_q, lms_start_d;
  logic              fir_start_q, fir_start_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              amb_lat_q, amb_lat_d;
  logic              fb_lat_q, fb_lat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic [CNT_W-1:0]  last_lat_q, last_lat_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic             timed_out;
  logic             timeout_set;
  logic             drop_ev;
  logic             amb_now;
  logic             fb_now;
  logic [CNT_W-1:0] lat_inc;
  logic [CNT_W-1:0] drop_base;

  always_comb begin
    state_d      = state_q;
    lp_start_d   = 1'b0;
    samp_start_d = 1'b0;
    lms_start_d  = 1'b0;
    fir_start_d  = 1'b0;
    frame_done_d = 1'b0;
    amb_lat_d    = amb_lat_q;
    fb_lat_d     = fb_lat_q;
    last_lat_d   = last_lat_q;
    timeout_set  = 1'b0;
    timed_out    = (wait_q == WAIT_LAST);
    wait_d       = wait_q + WAIT_W'(1);
    lat_inc      = (lat_q == CNT_MAX) ? lat_q : lat_q + CNT_W'(1);
    lat_d        = lat_inc;
    amb_now      = amb_lat_q | (lp_amb_done_in & ~lp_start_q);
    fb_now       = fb_lat_q | (lp_fb_done_in & ~lp_start_q);
    drop_ev      = sample_pulse_in && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (sample_pulse_in) begin
          state_d    = S_LP;
          lp_start_d = 1'b1;
          // Counts the accepting cycle itself, so the frame_done cycle lands on the latency.
          lat_d      = CNT_W'(1);
          amb_lat_d  = 1'b0;
          fb_lat_d   = 1'b0;
        end
      end
      S_LP: begin
        amb_lat_d = amb_now;
        fb_lat_d  = fb_now;
        if (amb_now && fb_now) begin
          state_d      = S_SAMP;
          samp_start_d = 1'b1;
          wait_d       = '0;
        end else if (timed_out) begin
          state_d     = S_IDLE;
          timeout_set = 1'b1;
        end
      end
      S_SAMP: begin
        if (samp_done_in && !samp_start_q) begin
          wait_d = '0;
          if (adapt_en_in) begin
            state_d     = S_ADAPT;
            lms_start_d = 1'b1;
          end else begin
            state_d     = S_FIR;
            fir_start_d = 1'b1;
          end
        end else if (timed_out) begin
          state_d     = S_IDLE;
          timeout_set = 1'b1;
        end
      end
      S_ADAPT: begin
        if (lms_done_in && !lms_start_q) begin
          state_d     = S_FIR;
          fir_start_d = 1'b1;
          wait_d      = '0;
        end else if (timed_out) begin
          state_d     = S_IDLE;
          timeout_set = 1'b1;
        end
      end
      S_FIR: begin
        if (fir_done_in && !fir_start_q) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          last_lat_d   = lat_inc;
        end else if (timed_out) begin
          state_d     = S_IDLE;
          timeout_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    // A set event in the same cycle as clear takes precedence.
    overrun_d = drop_ev | (overrun_q & ~clear_flags_in);
    timeout_d = timeout_set | (timeout_q & ~clear_flags_in);
    drop_base = clear_flags_in ? '0 : drop_q;
    drop_d    = drop_base;
    if (drop_ev && (drop_base != CNT_MAX)) drop_d = drop_base + CNT_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      lp_start_q   <= 1'b0;
      samp_start_q <= 1'b0;
      lms_start_q  <= 1'b0;
      fir_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      amb_lat_q    <= 1'b0;
      fb_lat_q     <= 1'b0;
      wait_q       <= '0;
      lat_q        <= '0;
      last_lat_q   <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      lp_start_q   <= lp_start_d;
      samp_start_q <= samp_start_d;
      lms_start_q  <= lms_start_d;
      fir_start_q  <= fir_start_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      amb_lat_q    <= amb_lat_d;
      fb_lat_q     <= fb_lat_d;
      wait_q       <= wait_d;
      lat_q        <= lat_d;
      last_lat_q   <= last_lat_d;
      drop_q       <= drop_d;
    end
  end

  assign lp_start_out     = lp_start_q;
  assign samp_start_out   = samp_start_q;
  assign lms_start_out    = lms_start_q;
  assign fir_start_out    = fir_start_q;
  assign frame_done_out   = frame_done_q;
  assign busy_out         = busy_q;
  assign overrun_out      = overrun_q;
  assign timeout_out      = timeout_q;
  assign drop_count_out   = drop_q;
  assign last_latency_out = last_lat_q;
  assign state_out        = state_q;

endmodule

// File: tb/tb_anc_scheduler.sv
// Bench for anc_scheduler: a cycle responder answers start pulses with done pulses,
// expected frame latencies are queued at stimulus time and popped at frame_done.
module tb_anc_scheduler;
  localparam int TO = 16;
  localparam int CW = 16;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          sample_pulse_in, adapt_en_in, clear_flags_in;
  logic          lp_start_out, lp_amb_done_in, lp_fb_done_in;
  logic          samp_start_out, samp_done_in;
  logic          lms_start_out, lms_done_in;
  logic          fir_start_out, fir_done_in;
  logic          frame_done_out, busy_out, overrun_out, timeout_out;
  logic [CW-1:0] drop_count_out, last_latency_out;
  logic [2:0]    state_out;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int last_lat_model = 0;

  always #5 clk_in = ~clk_in;

  anc_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .sample_pulse_in(sample_pulse_in), .adapt_en_in(adapt_en_in),
    .clear_flags_in(clear_flags_in),
    .lp_start_out(lp_start_out), .lp_amb_done_in(lp_amb_done_in), .lp_fb_done_in(lp_fb_done_in),
    .samp_start_out(samp_start_out), .samp_done_in(samp_done_in),
    .lms_start_out(lms_start_out), .lms_done_in(lms_done_in),
    .fir_start_out(fir_start_out), .fir_done_in(fir_done_in),
    .frame_done_out(frame_done_out), .busy_out(busy_out),
    .overrun_out(overrun_out), .timeout_out(timeout_out),
    .drop_count_out(drop_count_out), .last_latency_out(last_latency_out),
    .state_out(state_out)
  );

  task automatic idle_inputs();
    sample_pulse_in = 1'b0;
    clear_flags_in  = 1'b0;
    lp_amb_done_in  = 1'b0;
    lp_fb_done_in   = 1'b0;
    samp_done_in    = 1'b0;
    lms_done_in     = 1'b0;
    fir_done_in     = 1'b0;
  endtask

  // One frame: pulse at cycle 0, optional extra pulses from cycle 2, optional clear.
  task automatic run_frame(input bit adapt, input int amb_dly, input int fb_dly,
                           input bit hold_fir, input int drops, input int clr_cyc,
                           input string tag);
    int amb_cnt = 0, fb_cnt = 0, samp_cnt = 0, lms_cnt = 0, fir_cnt = 0;
    int seq_code = 0, exp_code;
    int fd_cyc = -1, idle_cyc = -1, lp_done_cyc = -1, samp_cyc = -1, fir_cyc = -1;
    int fd_count = 0, fir_state = -1, exp_lat, got;
    bit multi = 1'b0;
    exp_lat  = 2 + ((amb_dly > fb_dly) ? amb_dly : fb_dly) + (adapt ? 6 : 4);
    exp_code = adapt ? 1234 : 124;
    if (!hold_fir) exp_q.push_back(exp_lat);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk_in);
      idle_inputs();
      adapt_en_in     = adapt;
      sample_pulse_in = (cyc == 0) || (cyc >= 2 && cyc < 2 + drops);
      clear_flags_in  = (cyc == clr_cyc);
      if (amb_cnt > 0) begin amb_cnt--; if (amb_cnt == 0) begin lp_amb_done_in = 1'b1; lp_done_cyc = cyc; end end
      if (fb_cnt > 0) begin fb_cnt--; if (fb_cnt == 0) begin lp_fb_done_in = 1'b1; lp_done_cyc = cyc; end end
      if (samp_cnt > 0) begin samp_cnt--; if (samp_cnt == 0) samp_done_in = 1'b1; end
      if (lms_cnt > 0) begin lms_cnt--; if (lms_cnt == 0) lms_done_in = 1'b1; end
      if (fir_cnt > 0) begin fir_cnt--; if (fir_cnt == 0 && !hold_fir) fir_done_in = 1'b1; end
      if ($countones({lp_start_out, samp_start_out, lms_start_out, fir_start_out}) > 1) multi = 1'b1;
      if (lp_start_out) begin seq_code = seq_code * 10 + 1; amb_cnt = amb_dly; fb_cnt = fb_dly; end
      if (samp_start_out) begin seq_code = seq_code * 10 + 2; samp_cyc = cyc; samp_cnt = 1; end
      if (lms_start_out) begin seq_code = seq_code * 10 + 3; lms_cnt = 1; end
      if (fir_start_out) begin
        seq_code = seq_code * 10 + 4; fir_cyc = cyc; fir_cnt = 1; fir_state = int'(state_out);
      end
      if (frame_done_out) begin
        fd_count++;
        if (fd_cyc < 0) begin
          fd_cyc = cyc;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s sb_empty: frame_done with no expected entry", tag);
          end else begin
            got = exp_q.pop_front();
            last_lat_model = got;
            if (int'(last_latency_out) !== got) begin
              failures++;
              $display("FAIL %s latency: got %0d expected %0d", tag, last_latency_out, got);
            end
          end
        end
      end
      if (cyc > 1 && !busy_out && idle_cyc < 0) idle_cyc = cyc;
      if (idle_cyc >= 0 && cyc >= idle_cyc + 3) break;
    end
    idle_inputs();

    checks++;
    if (idle_cyc < 0) begin failures++; $display("FAIL %s return_idle: got busy expected idle", tag); end
    checks++;
    if (seq_code !== exp_code) begin failures++; $display("FAIL %s start_order: got %0d expected %0d", tag, seq_code, exp_code); end
    checks++;
    if (multi !== 1'b0) begin failures++; $display("FAIL %s one_start: got overlapping starts expected none", tag); end
    checks++;
    if (samp_cyc !== lp_done_cyc + 1) begin failures++; $display("FAIL %s samp_after_lp: got %0d expected %0d", tag, samp_cyc, lp_done_cyc + 1); end
    checks++;
    if (fir_state !== 4) begin failures++; $display("FAIL %s fir_state: got %0d expected 4", tag, fir_state); end
    if (!hold_fir) begin
      checks++;
      if (fd_count !== 1) begin failures++; $display("FAIL %s frame_done_count: got %0d expected 1", tag, fd_count); end
      checks++;
      if (fd_cyc !== exp_lat) begin failures++; $display("FAIL %s frame_done_cycle: got %0d expected %0d", tag, fd_cyc, exp_lat); end
    end else begin
      checks++;
      if (fd_count !== 0) begin failures++; $display("FAIL %s no_frame_done: got %0d expected 0", tag, fd_count); end
      checks++;
      if (idle_cyc !== fir_cyc + TO) begin failures++; $display("FAIL %s timeout_cycle: got %0d expected %0d", tag, idle_cyc, fir_cyc + TO); end
      checks++;
      if (timeout_out !== 1'b1) begin failures++; $display("FAIL %s timeout_flag: got %0b expected 1", tag, timeout_out); end
      checks++;
      if (int'(last_latency_out) !== last_lat_model) begin
        failures++; $display("FAIL %s latency_kept: got %0d expected %0d", tag, last_latency_out, last_lat_model);
      end
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    idle_inputs();
    adapt_en_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({lp_start_out, samp_start_out, lms_start_out, fir_start_out, frame_done_out,
         busy_out, overrun_out, timeout_out, state_out} !== 11'd0) begin
      failures++; $display("FAIL reset_ctrl: got nonzero control outputs expected 0");
    end
    checks++;
    if (drop_count_out !== '0 || last_latency_out !== '0) begin
      failures++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", drop_count_out, last_latency_out);
    end
    rst_n_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_idle: got busy %0b expected 0", busy_out); end
  endtask

  task automatic test_basic();
    run_frame(1'b1, 1, 1, 1'b0, 0, -1, "adapt_on");
    run_frame(1'b0, 1, 1, 1'b0, 0, -1, "adapt_off");
  endtask

  task automatic test_lp_skew();
    run_frame(1'b1, 4, 1, 1'b0, 0, -1, "fb_first");
    run_frame(1'b0, 1, 3, 1'b0, 0, -1, "amb_first");
  endtask

  task automatic test_overrun();
    run_frame(1'b1, 1, 1, 1'b0, 3, -1, "overrun3");
    checks++;
    if (drop_count_out !== 16'd3) begin failures++; $display("FAIL drop_count: got %0d expected 3", drop_count_out); end
    checks++;
    if (overrun_out !== 1'b1) begin failures++; $display("FAIL overrun_set: got %0b expected 1", overrun_out); end
    @(negedge clk_in); clear_flags_in = 1'b1;
    @(negedge clk_in); clear_flags_in = 1'b0;
    checks++;
    if (drop_count_out !== '0 || overrun_out !== 1'b0) begin
      failures++; $display("FAIL clear: got %0d/%0b expected 0/0", drop_count_out, overrun_out);
    end
    run_frame(1'b1, 2, 2, 1'b0, 1, 2, "set_wins");
    checks++;
    if (drop_count_out !== 16'd1 || overrun_out !== 1'b1) begin
      failures++; $display("FAIL set_wins_flags: got %0d/%0b expected 1/1", drop_count_out, overrun_out);
    end
    checks++;
    if (timeout_out !== 1'b0) begin failures++; $display("FAIL no_timeout: got %0b expected 0", timeout_out); end
  endtask

  task automatic test_timeout();
    run_frame(1'b1, 1, 1, 1'b1, 0, -1, "fir_timeout");
  endtask

  task automatic test_reset_mid_frame();
    bit reached = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk_in);
      idle_inputs();
      adapt_en_in     = 1'b1;
      sample_pulse_in = (cyc == 0);
      lp_amb_done_in  = (cyc == 2);
      lp_fb_done_in   = (cyc == 2);
      samp_done_in    = (cyc == 4);
      if (state_out == 3'd3) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL reach_adapt: got state %0d expected 3", state_out); end
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if ({lms_start_out, frame_done_out, busy_out, timeout_out, overrun_out, state_out} !== 8'd0) begin
      failures++; $display("FAIL async_reset: got state %0d busy %0b lms %0b expected all 0", state_out, busy_out, lms_start_out);
    end
    checks++;
    if (last_latency_out !== '0 || drop_count_out !== '0) begin
      failures++; $display("FAIL async_reset_counts: got %0d/%0d expected 0/0", last_latency_out, drop_count_out);
    end
    last_lat_model = 0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    run_frame(1'b1, 1, 1, 1'b0, 0, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                1'b0, 0, -1, "random");
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lp_skew();
    test_overrun();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anc_scheduler.md
ANC_SCHEDULER -- requirements
Module: anc_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2047: max cycles allowed in any wait state before abort.
REQ-002 Parameter CNT_W, default 16: width of drop_count_out and last_latency_out.
REQ-003 clk_in  input  1  system clock (100 MHz); one clock domain.
REQ-004 rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 sample_pulse_in  input  1  one-cycle pulse; new mic sample pair available.
REQ-006 adapt_en_in  input  1  high = run NLMS weight update each frame; low = freeze weights.
REQ-007 clear_flags_in  input  1  clears sticky flags and drop_count_out.
REQ-008 lp_start_out  output  1  one-cycle start to both lowpass filters.
REQ-009 lp_amb_done_in, lp_fb_done_in  input  1 each  lowpass done pulses, any order.
REQ-010 samp_start_out / samp_done_in  output / input  1  sample-buffer push start / done.
REQ-011 lms_start_out / lms_done_in  output / input  1  NLMS update start / done.
REQ-012 fir_start_out / fir_done_in  output / input  1  FIR compute start / done.
REQ-013 frame_done_out  output  1  one-cycle pulse; speaker sample valid.
REQ-014 busy_out  output  1  high whenever state is not IDLE.
REQ-015 overrun_out, timeout_out  output  1 each  sticky error flags.
REQ-016 drop_count_out  output  CNT_W  saturating count of rejected sample pulses.
REQ-017 last_latency_out  output  CNT_W  cycles from accept to frame_done of last completed frame.
REQ-018 state_out  output  3  encoded current state for debug.

Function
REQ-019 States: IDLE=0, LP=1, SAMP=2, ADAPT=3, FIR=4; all outputs registered.
REQ-020 IDLE + sample_pulse_in: next cycle enter LP, lp_start_out=1 for exactly that cycle.
REQ-021 LP: latch each lowpass done independently; both latched (incl. same cycle) -> next cycle SAMP with samp_start_out=1.
REQ-022 SAMP + samp_done_in: adapt_en_in=1 -> ADAPT with lms_start_out=1; adapt_en_in=0 -> FIR with fir_start_out=1 (ADAPT skipped).
REQ-023 ADAPT + lms_done_in -> FIR, fir_start_out=1 next cycle.
REQ-024 FIR + fir_done_in -> IDLE, frame_done_out=1 next cycle; last_latency_out updated same cycle.
REQ-025 Done inputs ignored in the start-pulse cycle of their own stage and in all other states.
REQ-026 Start pulses never exceed one cycle; at most one start output high per cycle.
REQ-027 Latency counter: zeroed at accept, +1 per cycle, saturates at 2^CNT_W-1; minimum frame (all dones 1 cycle after start, adapt on) = 9 cycles.
REQ-028 sample_pulse_in while state != IDLE (incl. cycle of fir_done_in): pulse dropped, overrun_out<=1, drop_count_out+1 saturating at all-ones.
REQ-029 Stage wait counter zeroed on each state entry; reaching TIMEOUT_CYCLES in LP/SAMP/ADAPT/FIR -> IDLE, timeout_out<=1, no frame_done_out, last_latency_out unchanged.
REQ-030 clear_flags_in clears overrun_out, timeout_out, drop_count_out; a set event in the same cycle wins (flag=1, count=1).
REQ-031 adapt_en_in sampled only at the SAMP exit cycle; changes mid-frame affect next frame.

Reset
REQ-032 rst_n_in low: immediately state IDLE, all start outputs, frame_done_out, busy_out, flags =0, counters =0, state_out=0.
REQ-033 Reset mid-frame aborts without frame_done_out; operation resumes on first sample_pulse_in after release.

Verification
REQ-034 Pulse, all dones 1 cycle after start, adapt on -> starts LP,SAMP,ADAPT,FIR in order, frame_done_out once, last_latency_out=9.
REQ-035 adapt_en_in=0, same stimulus -> lms_start_out never high, last_latency_out=7.
REQ-036 lp_fb_done 3 cycles before lp_amb_done -> samp_start_out 1 cycle after lp_amb_done only.
REQ-037 Three sample pulses during one frame -> drop_count_out=3, overrun_out=1; clear_flags_in -> both 0.
REQ-038 TIMEOUT_CYCLES=16, fir_done_in withheld -> IDLE after 16 FIR cycles, timeout_out=1, no frame_done_out.
REQ-039 rst_n_in asserted in ADAPT -> outputs 0 without clock edge; next pulse runs full frame normally.
